// File: rtl/burst_tracker_pkg.sv
// Shared types and constants for the PSRAM burst tracker.
// State encoding, config register address and latency field width.
package burst_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [15:0] CFG_LATENCY_ADDR = 16'h7010;
    localparam int          LAT_W            = 4;

    typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/burst_tracker_sync_edge.sv
// Two-flop synchronizer with rising-edge detect for the raw RAM clock.
// rise is high for one mclk per synchronized low-to-high transition.
module sync_edge (
    input  logic mclk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Resynchronize and keep one older sample for edge detection
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/burst_tracker.sv
// Tracks PSRAM bursts seen on raw RAM pins and drives patched read data.
// Optional stall timeout: define BURST_TRACKER_TIMEOUT_EN.
module burst_tracker
    import burst_tracker_pkg::*;
#(
    parameter int LATENCY_DEFAULT = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        ram_clk,
    input  logic        ram_ce_n,
    input  logic        ram_adv_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    input  logic [22:0] ram_addr,
    input  logic [15:0] config_addr,
    input  logic [15:0] config_data,
    input  logic        config_strobe,
    input  logic        patch_trigger,
    input  logic [15:0] patch_data,
    output logic [22:0] burst_addr,
    output logic        burst_addr_strobe,
    output logic        patch_data_next,
    output logic [15:0] ram_data_out,
    output logic        ram_data_oe,
    output logic        burst_active
);

    logic [3:0] ctl_s1;
    logic [3:0] ctl_s2;
    logic       ce_s;
    logic       adv_s;
    logic       oe_s;
    logic       we_s;
    logic       rclk_rise;
    logic       armed;
    logic       addr_edge;
    logic       timeout;
    logic       leave;
    state_t     state;
    lat_t       lat_reg;
    lat_t       lat_cur;
    lat_t       cnt;
    lat_t       cnt_nxt;
    logic       patching;
    logic       data_first;
    logic       unused_cfg;

    sync_edge u_rclk (
        .mclk  (mclk),
        .reset (reset),
        .din   (ram_clk),
        .rise  (rclk_rise)
    );

    // Control lines share the ram_clk synchronizer depth
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ctl_s1 <= '0;
            ctl_s2 <= '0;
        end else begin
            ctl_s1 <= {ram_ce_n, ram_adv_n, ram_oe_n, ram_we_n};
            ctl_s2 <= ctl_s1;
        end
    end

    assign {ce_s, adv_s, oe_s, we_s} = ctl_s2;

    // After reset, wait for ce_n high so a half-seen burst is ignored
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (ce_s) begin
            armed <= 1'b1;
        end
    end

    assign addr_edge = armed & rclk_rise & ~ce_s & ~adv_s;
    assign cnt_nxt   = cnt + lat_t'(1);
    assign leave     = ce_s | addr_edge | timeout;

`ifdef BURST_TRACKER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tcnt;

    // Count mclk cycles since the last RAM clock edge of an open burst
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == IDLE || rclk_rise || timeout) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 8'd1;
        end
    end

    assign timeout = (state != IDLE) && !rclk_rise && (tcnt == TO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // Latency register; a burst snapshots it at its address edge
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            lat_reg <= lat_t'(LATENCY_DEFAULT);
        end else if (config_strobe && config_addr == CFG_LATENCY_ADDR) begin
            lat_reg <= config_data[LAT_W-1:0];
        end
    end

    assign unused_cfg = ^config_data[15:LAT_W];

    // Burst sequencer: address edge, latency count, data or write phase
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_cur    <= '0;
            patching   <= 1'b0;
            data_first <= 1'b0;
        end else if (ce_s || timeout) begin
            state      <= IDLE;
            cnt        <= '0;
            patching   <= 1'b0;
            data_first <= 1'b0;
        end else if (addr_edge) begin
            cnt      <= '0;
            lat_cur  <= lat_reg;
            patching <= 1'b0;
            if (!we_s) begin
                state      <= WRITE;
                data_first <= 1'b0;
            end else if (lat_reg == '0) begin
                state      <= DATA;
                data_first <= 1'b1;
            end else begin
                state      <= WAIT;
                data_first <= 1'b0;
            end
        end else begin
            data_first <= 1'b0;
            unique case (state)
                WAIT: begin
                    if (patch_trigger) begin
                        patching <= 1'b1;
                    end
                    if (rclk_rise) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == lat_cur) begin
                            state      <= DATA;
                            data_first <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (data_first && patch_trigger) begin
                        patching <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; any exit condition kills oe and pulses at once
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            burst_addr        <= '0;
            burst_addr_strobe <= 1'b0;
            patch_data_next   <= 1'b0;
            ram_data_out      <= '0;
            ram_data_oe       <= 1'b0;
        end else begin
            if (addr_edge) begin
                burst_addr <= ram_addr;
            end
            burst_addr_strobe <= addr_edge;
            patch_data_next   <= (state == DATA) & patching & rclk_rise & ~leave;
            ram_data_out      <= patch_data;
            ram_data_oe       <= (state == DATA) & patching & ~oe_s & ~leave;
        end
    end

    assign burst_active = (state != IDLE);

endmodule

// File: tb/tb_burst_tracker.sv
// Directed bench for burst_tracker: table of bursts plus corner sequences.
// Expected values come from the vector table and hand-written sequences.
module tb_burst_tracker;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_clk = 1'b0;
    logic        ram_ce_n = 1'b1;
    logic        ram_adv_n = 1'b1;
    logic        ram_oe_n = 1'b0;
    logic        ram_we_n = 1'b1;
    logic [22:0] ram_addr = '0;
    logic [15:0] config_addr = '0;
    logic [15:0] config_data = '0;
    logic        config_strobe = 1'b0;
    logic        patch_trigger = 1'b0;
    logic [15:0] patch_data = '0;
    logic [22:0] burst_addr;
    logic        burst_addr_strobe;
    logic        patch_data_next;
    logic [15:0] ram_data_out;
    logic        ram_data_oe;
    logic        burst_active;

    burst_tracker dut (
        .mclk              (mclk),
        .reset             (reset),
        .ram_clk           (ram_clk),
        .ram_ce_n          (ram_ce_n),
        .ram_adv_n         (ram_adv_n),
        .ram_oe_n          (ram_oe_n),
        .ram_we_n          (ram_we_n),
        .ram_addr          (ram_addr),
        .config_addr       (config_addr),
        .config_data       (config_data),
        .config_strobe     (config_strobe),
        .patch_trigger     (patch_trigger),
        .patch_data        (patch_data),
        .burst_addr        (burst_addr),
        .burst_addr_strobe (burst_addr_strobe),
        .patch_data_next   (patch_data_next),
        .ram_data_out      (ram_data_out),
        .ram_data_oe       (ram_data_oe),
        .burst_active      (burst_active)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        we_n;
        int          trig;
        logic        cfg_en;
        logic [15:0] cfg_addr;
        logic [15:0] cfg_data;
        int          lat;
        int          ndata;
        logic [22:0] addr;
        logic [15:0] pdata;
        logic [1:0]  exp_state;
        int          exp_pulses;
        int          exp_oe;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int passed = 0;
    int rises = 0;

    int          n_strobe = 0;
    int          n_pulse = 0;
    int          n_oe_rise = 0;
    int          oe_beat = -1;
    logic [22:0] last_addr = '0;
    logic        oe_q = 1'b0;

    // Event monitor, sampled on the inactive edge
    always @(negedge mclk) begin
        if (burst_addr_strobe) begin
            n_strobe  = n_strobe + 1;
            last_addr = burst_addr;
        end
        if (patch_data_next) n_pulse = n_pulse + 1;
        if (ram_data_oe && !oe_q) begin
            n_oe_rise = n_oe_rise + 1;
            oe_beat   = rises;
        end
        oe_q = ram_data_oe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic cfg_write(input logic [15:0] a, input logic [15:0] d);
        config_addr   = a;
        config_data   = d;
        config_strobe = 1'b1;
        @(negedge mclk);
        config_strobe = 1'b0;
        @(negedge mclk);
    endtask

    task automatic data_beat();
        rises   = rises + 1;
        ram_clk = 1'b1;
        repeat (4) @(negedge mclk);
        ram_clk = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic addr_beat(input logic [22:0] a, input logic we);
        rises     = 0;
        ram_ce_n  = 1'b0;
        ram_adv_n = 1'b0;
        ram_we_n  = we;
        ram_addr  = a;
        ram_clk   = 1'b1;
        repeat (4) @(negedge mclk);
        ram_clk   = 1'b0;
        ram_adv_n = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    task automatic end_burst();
        ram_ce_n      = 1'b1;
        patch_trigger = 1'b0;
        repeat (6) @(negedge mclk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        int p0;
        int o0;
        if (v.cfg_en) cfg_write(v.cfg_addr, v.cfg_data);
        s0 = n_strobe;
        p0 = n_pulse;
        o0 = n_oe_rise;
        patch_trigger = (v.trig == 1);
        patch_data    = v.pdata;
        addr_beat(v.addr, v.we_n);
        for (int i = 0; i < v.lat + v.ndata; i++) begin
            if (v.trig == 2 && i == v.lat + 1) patch_trigger = 1'b1;
            data_beat();
        end
        check({tag, " state"}, 32'(dut.state), 32'(v.exp_state));
        check({tag, " data_out"}, 32'(ram_data_out), 32'(v.pdata));
        end_burst();
        check({tag, " strobes"}, n_strobe - s0, 1);
        check({tag, " addr"}, 32'(last_addr), 32'(v.addr));
        check({tag, " pulses"}, n_pulse - p0, v.exp_pulses);
        check({tag, " oe_rises"}, n_oe_rise - o0, v.exp_oe);
        if (v.exp_oe != 0) check({tag, " oe_beat"}, oe_beat, v.lat);
        check({tag, " idle_active"}, 32'(burst_active), 0);
        check({tag, " idle_oe"}, 32'(ram_data_oe), 0);
    endtask

    initial begin
        int s0;
        int p0;
        int o0;
        vec_t v;

        vecs[0] = '{1'b1, 1, 1'b0, 16'h0000, 16'h0000, 3, 4, 23'h001234, 16'hA5C3, 2'd2, 4, 1};
        vecs[1] = '{1'b1, 0, 1'b0, 16'h0000, 16'h0000, 3, 4, 23'h001234, 16'h1111, 2'd2, 0, 0};
        vecs[2] = '{1'b0, 1, 1'b0, 16'h0000, 16'h0000, 0, 3, 23'h000ABC, 16'h2222, 2'd3, 0, 0};
        vecs[3] = '{1'b1, 1, 1'b1, 16'h7011, 16'h0009, 3, 2, 23'h400001, 16'h3333, 2'd2, 2, 1};
        vecs[4] = '{1'b1, 1, 1'b1, 16'h7010, 16'h0005, 5, 3, 23'h7FFFFF, 16'h4444, 2'd2, 3, 1};
        vecs[5] = '{1'b1, 2, 1'b0, 16'h0000, 16'h0000, 5, 3, 23'h000010, 16'h5555, 2'd2, 0, 0};
        vecs[6] = '{1'b1, 1, 1'b1, 16'h7010, 16'h0000, 0, 2, 23'h000000, 16'h6666, 2'd2, 2, 1};
        vecs[7] = '{1'b1, 1, 1'b1, 16'h7010, 16'hFFF3, 3, 1, 23'h2AAAAA, 16'h7777, 2'd2, 1, 1};

        patch_data = 16'hBEEF;
        repeat (3) @(negedge mclk);
        check("rst state", 32'(dut.state), 0);
        check("rst oe", 32'(ram_data_oe), 0);
        check("rst strobe", 32'(burst_addr_strobe), 0);
        check("rst next", 32'(patch_data_next), 0);
        check("rst active", 32'(burst_active), 0);
        check("rst addr", 32'(burst_addr), 0);
        check("rst data_out", 32'(ram_data_out), 0);
        reset = 1'b0;
        repeat (5) @(negedge mclk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Config write lands in the same mclk as the address edge
        s0 = n_strobe;
        o0 = n_oe_rise;
        patch_trigger = 1'b1;
        rises     = 0;
        ram_ce_n  = 1'b0;
        ram_adv_n = 1'b0;
        ram_we_n  = 1'b1;
        ram_addr  = 23'h055555;
        ram_clk   = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        config_addr   = 16'h7010;
        config_data   = 16'h0001;
        config_strobe = 1'b1;
        @(negedge mclk);
        config_strobe = 1'b0;
        @(negedge mclk);
        ram_clk   = 1'b0;
        ram_adv_n = 1'b1;
        repeat (4) @(negedge mclk);
        for (int i = 0; i < 5; i++) data_beat();
        end_burst();
        check("samecyc strobes", n_strobe - s0, 1);
        check("samecyc oe_rises", n_oe_rise - o0, 1);
        check("samecyc oe_beat", oe_beat, 3);
        v = '{1'b1, 1, 1'b0, 16'h0, 16'h0, 1, 2, 23'h012345, 16'h9999, 2'd2, 2, 1};
        run_vec(v, "nextlat");

        // ce_n rises during the second data beat
        p0 = n_pulse;
        patch_trigger = 1'b1;
        addr_beat(23'h003000, 1'b1);
        data_beat();
        data_beat();
        rises   = rises + 1;
        ram_clk = 1'b1;
        repeat (4) @(negedge mclk);
        check("abort oe_before", 32'(ram_data_oe), 1);
        ram_ce_n = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        check("abort oe_sync", 32'(ram_data_oe), 1);
        @(negedge mclk);
        check("abort oe_drop", 32'(ram_data_oe), 0);
        check("abort state", 32'(dut.state), 0);
        check("abort active", 32'(burst_active), 0);
        ram_clk = 1'b0;
        repeat (4) @(negedge mclk);
        data_beat();
        data_beat();
        check("abort pulses", n_pulse - p0, 2);
        end_burst();

        // Reset mid-burst, then a burst already in progress is ignored
        patch_trigger = 1'b1;
        addr_beat(23'h006000, 1'b1);
        for (int i = 0; i < 2; i++) data_beat();
        check("rstmid oe_before", 32'(ram_data_oe), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid oe_async", 32'(ram_data_oe), 0);
        check("rstmid active", 32'(burst_active), 0);
        @(negedge mclk);
        reset = 1'b0;
        s0 = n_strobe;
        o0 = n_oe_rise;
        repeat (3) @(negedge mclk);
        addr_beat(23'h007000, 1'b1);
        for (int i = 0; i < 4; i++) data_beat();
        check("ignored strobes", n_strobe - s0, 0);
        check("ignored oe", n_oe_rise - o0, 0);
        check("ignored active", 32'(burst_active), 0);
        end_burst();
        run_vec(vecs[0], "recover");

        // RAM clock stalls in WAIT
        patch_trigger = 1'b0;
        addr_beat(23'h008000, 1'b1);
        repeat (196) @(negedge mclk);
        check("stall early active", 32'(burst_active), 1);
        repeat (100) @(negedge mclk);
`ifdef BURST_TRACKER_TIMEOUT_EN
        check("stall timeout active", 32'(burst_active), 0);
        check("stall timeout state", 32'(dut.state), 0);
`else
        check("stall hold active", 32'(burst_active), 1);
        check("stall hold state", 32'(dut.state), 1);
`endif
        end_burst();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
